// File: rtl/isp_wb_master.sv
// isp_wb_master -- single-outstanding Wishbone classic bus master.
//
// Accepts one command at a time on a valid/ready handshake, runs exactly one
// Wishbone classic cycle for it and returns the result on a valid/ready
// response channel.
//
// Optional feature macro: ISP_WB_MASTER_TIMEOUT_EN
//   defined   : a bus cycle that sees no wbm_ack_i for TIMEOUT_CYCLES cycles
//               is aborted and answered with rsp_err=1, rsp_dat=0.
//   undefined : the master waits for wbm_ack_i indefinitely; rsp_err is 0.
//
// Ports
//   wb_clk_i, wb_rst_i       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_we/adr/dat/sel payload
//   rsp_valid/rsp_ready      response handshake; rsp_dat, rsp_err payload
//   busy                     high whenever the master is not idle
//   wbm_*                    Wishbone classic master signals
module isp_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        accept_s;
    logic        done_s;
    logic        abort_s;
    logic        timeout_hit_s;
    logic        cyc_r;
    logic        we_r;
    logic [3:0]  sel_r;
    logic [31:0] adr_r;
    logic [31:0] dat_r;
    logic [31:0] rsp_dat_r;
    logic        rsp_err_r;

`ifdef ISP_WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] tmo_cnt_r;

    // Abort when this BUS cycle would be the TIMEOUT_CYCLES-th without ack.
    assign timeout_hit_s = ((tmo_cnt_r + 16'd1) == TIMEOUT_LIMIT);

    // Timeout counter: cleared on BUS entry, counts BUS cycles without ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt_r <= 16'd0;
        end else if (accept_s) begin
            tmo_cnt_r <= 16'd0;
        end else if ((state_r == ST_BUS) && !wbm_ack_i) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end
    end
`else
    logic unused_timeout_s;
    assign unused_timeout_s = |TIMEOUT_CYCLES;
    assign timeout_hit_s    = 1'b0;
`endif

    // Next-state decode and one-cycle event strobes.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    next_state_s = ST_BUS;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                // Ack takes priority over a timeout in the same cycle.
                if (wbm_ack_i) begin
                    next_state_s = ST_RESP;
                    done_s       = 1'b1;
                end else if (timeout_hit_s) begin
                    next_state_s = ST_RESP;
                    abort_s      = 1'b1;
                end else begin
                    next_state_s = ST_BUS;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, bus request registers and response registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r   <= ST_IDLE;
            cyc_r     <= 1'b0;
            we_r      <= 1'b0;
            sel_r     <= 4'd0;
            adr_r     <= 32'd0;
            dat_r     <= 32'd0;
            rsp_dat_r <= 32'd0;
            rsp_err_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                cyc_r <= 1'b1;
                we_r  <= cmd_we;
                sel_r <= cmd_sel;
                adr_r <= cmd_adr;
                dat_r <= cmd_dat;
            end
            if (done_s) begin
                cyc_r     <= 1'b0;
                rsp_dat_r <= we_r ? 32'd0 : wbm_dat_i;
                rsp_err_r <= 1'b0;
            end
            if (abort_s) begin
                cyc_r     <= 1'b0;
                rsp_dat_r <= 32'd0;
                rsp_err_r <= 1'b1;
            end
        end
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_dat   = rsp_dat_r;
    assign rsp_err   = rsp_err_r;
    // Classic cycles: strobe is asserted for the whole cycle.
    assign wbm_cyc_o = cyc_r;
    assign wbm_stb_o = cyc_r;
    assign wbm_we_o  = we_r;
    assign wbm_sel_o = sel_r;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;

endmodule

// File: tb/tb_isp_wb_master.sv
// Self-checking bench for isp_wb_master: directed scenarios plus randomized
// transactions, compared against a transaction-level expectation model.
module tb_isp_wb_master;

    localparam int TO = 8;
`ifdef ISP_WB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic [3:0]  cmd_sel = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'd0;
    logic        wbm_ack_i = 1'b0;

    int checks = 0;
    int failures = 0;

    // Expected bus request (the last accepted command) and response.
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_adr, exp_dat, exp_rdat;
    logic        exp_err;

    isp_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    // Free-running clock, 10 time units per period.
    always #5 wb_clk_i = ~wb_clk_i;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Offer a command in IDLE; returns at the negedge after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        chk("idle_cmd_ready", cmd_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        cmd_valid = 1'b1;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        exp_we = we; exp_adr = adr; exp_dat = dat; exp_sel = sel;
        @(negedge wb_clk_i);
    endtask

    // Bus phase: the slave acks in BUS cycle ack_delay (0 = first cycle).
    // Meanwhile the command inputs are scrambled and must be ignored.
    task automatic bus_phase(input int ack_delay, input logic [31:0] rdata);
        int n;
        bit aborted;
        aborted = TO_EN && (ack_delay >= TO);
        n = aborted ? TO : ack_delay + 1;
        exp_rdat = (aborted || exp_we) ? 32'd0 : rdata;
        exp_err = aborted;
        for (int c = 0; c < n; c++) begin
            chk("bus_cyc", wbm_cyc_o, 1'b1);
            chk("bus_stb", wbm_stb_o, 1'b1);
            chk("bus_we", wbm_we_o, exp_we);
            chk("bus_adr", wbm_adr_o, exp_adr);
            chk("bus_dat", wbm_dat_o, exp_dat);
            chk("bus_sel", wbm_sel_o, exp_sel);
            chk("bus_cmd_ready", cmd_ready, 1'b0);
            chk("bus_busy", busy, 1'b1);
            chk("bus_rsp_valid", rsp_valid, 1'b0);
            wbm_ack_i = (c == ack_delay);
            wbm_dat_i = (c == ack_delay) ? rdata : $urandom;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we = 1'($urandom_range(0, 1));
            cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
            @(negedge wb_clk_i);
        end
        wbm_ack_i = 1'b0;
        cmd_valid = 1'b0;
    endtask

    // Response phase with bp cycles of backpressure and spurious acks.
    task automatic resp_phase(input int bp);
        for (int i = 0; i <= bp; i++) begin
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_dat", rsp_dat, exp_rdat);
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_cyc", wbm_cyc_o, 1'b0);
            chk("rsp_stb", wbm_stb_o, 1'b0);
            chk("rsp_cmd_ready", cmd_ready, 1'b0);
            chk("rsp_adr_held", wbm_adr_o, exp_adr);
            rsp_ready = (i == bp);
            wbm_ack_i = 1'($urandom_range(0, 1));
            wbm_dat_i = $urandom;
            @(negedge wb_clk_i);
        end
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] rd;
        // Reset state while reset is asserted.
        #1;
        chk("rst_cyc", wbm_cyc_o, 1'b0);
        chk("rst_stb", wbm_stb_o, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_sel", wbm_sel_o, 4'd0);
        chk("rst_we", wbm_we_o, 1'b0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Write acked after three cycles.
        issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        bus_phase(2, 32'hDEAD_BEEF);
        resp_phase(0);

        // Read acked in the first BUS cycle (minimum latency).
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        bus_phase(0, 32'hCAFE_0001);
        resp_phase(1);

        // Spurious acks while idle must change nothing.
        for (int i = 0; i < 3; i++) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = $urandom;
            @(negedge wb_clk_i);
            chk("idle_ack_busy", busy, 1'b0);
            chk("idle_ack_cyc", wbm_cyc_o, 1'b0);
            chk("idle_ack_rsp_valid", rsp_valid, 1'b0);
            chk("idle_ack_adr", wbm_adr_o, 32'h3000_0010);
        end
        wbm_ack_i = 1'b0;

        // Backpressure with the next command held on the input.
        issue(1'b0, 32'h0000_0100, 32'h0, 4'h3);
        bus_phase(0, 32'h1234_5678);
        cmd_valid = 1'b1; cmd_we = 1'b1;
        cmd_adr = 32'h0000_0200; cmd_dat = 32'h5555_AAAA; cmd_sel = 4'hC;
        resp_phase(5);
        issue(1'b1, 32'h0000_0200, 32'h5555_AAAA, 4'hC);
        bus_phase(1, 32'h0);
        resp_phase(0);

        // No ack for a long time: aborts when timeout is built in.
        issue(1'b0, 32'h0000_0300, 32'h0, 4'hF);
        bus_phase(TO + 6, 32'h7777_7777);
        resp_phase(0);

        // Ack in the last cycle before the timeout.
        issue(1'b0, 32'h0000_0304, 32'h0, 4'hF);
        bus_phase(TO - 1, 32'h8888_0001);
        resp_phase(0);

        // Asynchronous reset in the middle of a bus cycle.
        issue(1'b1, 32'h0000_0400, 32'h1111_2222, 4'hF);
        cmd_valid = 1'b0;
        chk("pre_rst_cyc", wbm_cyc_o, 1'b1);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("async_rst_cyc", wbm_cyc_o, 1'b0);
        chk("async_rst_stb", wbm_stb_o, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_rsp_valid", rsp_valid, 1'b0);
        chk("async_rst_adr", wbm_adr_o, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        chk("after_rst_rsp_valid", rsp_valid, 1'b0);
        issue(1'b0, 32'h0000_0500, 32'h0, 4'hF);
        bus_phase(1, 32'h0BAD_F00D);
        resp_phase(2);

        // Randomized transactions.
        for (int t = 0; t < 25; t++) begin
            rd = $urandom;
            issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
            bus_phase(int'($urandom_range(0, 11)), rd);
            resp_phase(int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/isp_wb_master.md
ISP_WB_MASTER -- requirements
Module: isp_wb_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max wait cycles for wbm_ack_i before abort (range 1..65535).
REQ-002 wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 wb_rst_i  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when high with cmd_valid at a clock edge.
REQ-006 cmd_we  input  1  1 = write, 0 = read.
REQ-007 cmd_adr  input  32  byte address.
REQ-008 cmd_dat  input  32  write data.
REQ-009 cmd_sel  input  4  byte lane select.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when high with rsp_valid at a clock edge.
REQ-012 rsp_dat  output  32  read data; 0 for writes and aborts.
REQ-013 rsp_err  output  1  1 = cycle aborted by timeout.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 wbm_cyc_o, wbm_stb_o  output  1 each  Wishbone classic cycle/strobe.
REQ-016 wbm_we_o  output  1; wbm_sel_o  output  4; wbm_adr_o  output  32; wbm_dat_o  output  32.
REQ-017 wbm_dat_i  input  32  read data; wbm_ack_i  input  1  slave acknowledge.

Function
REQ-018 FSM states IDLE, BUS, RESP; one outstanding transaction at a time, no pipelining.
REQ-019 IDLE: cmd_ready=1; on cmd_valid, latch we/adr/dat/sel into wbm_* registers and enter BUS; cyc=stb=1 from the cycle after the accepting edge.
REQ-020 BUS: cmd_ready=0; wbm_* outputs held stable until ack or abort.
REQ-021 BUS: at the edge wbm_ack_i=1 is sampled, capture wbm_dat_i into rsp_dat for reads (0 for writes), clear rsp_err, drop cyc/stb, enter RESP.
REQ-022 Minimum latency: ack at the first BUS cycle gives rsp_valid=1 two cycles after the accepting edge.
REQ-023 RESP: rsp_valid=1, rsp_dat/rsp_err stable until rsp_ready sampled high, then IDLE; a new command can be accepted no earlier than the cycle after.
REQ-024 wbm_ack_i outside BUS ignored; cmd_valid outside IDLE ignored, without loss of the held command.
REQ-025 wbm_we_o/sel/adr/dat hold last value after cycle end; wbm_cyc_o always equals wbm_stb_o.

Reset
REQ-026 wb_rst_i asserted: immediately (no clock) state=IDLE, wbm_cyc_o=wbm_stb_o=0, rsp_valid=0, rsp_err=0, busy=0, rsp_dat=0, wbm_adr_o/dat/sel/we=0, timeout counter=0.
REQ-027 Reset mid-BUS aborts the cycle without response; after deassertion, cmd_ready=1 from the first clock cycle.

Configuration
REQ-028 Macro ISP_WB_MASTER_TIMEOUT_EN defined: 16-bit counter cleared on BUS entry, incremented each BUS cycle without ack.
REQ-029 Abort rule with the macro defined: when the counter reaches TIMEOUT_CYCLES without ack, drop cyc/stb, rsp_dat=0, rsp_err=1, enter RESP.
REQ-030 Ack/timeout tie with the macro defined: ack in the same cycle as timeout wins (normal response, rsp_err=0).
REQ-031 Macro ISP_WB_MASTER_TIMEOUT_EN undefined: no counter; BUS waits indefinitely; rsp_err constant 0; TIMEOUT_CYCLES unused.

Verification
REQ-032 Write: cmd adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF, ack after 3 cycles -> one Wishbone cycle of 3 cycles with matching outputs; rsp_valid, rsp_dat=0, rsp_err=0.
REQ-033 Read: adr=0x3000_0010, slave returns 0xCAFE_0001 with ack at first BUS cycle -> rsp_valid 2 cycles after accept, rsp_dat=0xCAFE_0001.
REQ-034 Backpressure: rsp_ready low 5 cycles, cmd_valid held high -> rsp_valid/rsp_dat stable, cmd_ready=0 throughout, second command accepted the cycle after the handshake.
REQ-035 Timeout (macro defined, TIMEOUT_CYCLES=8, no ack) -> cyc/stb drop after 8 BUS cycles, rsp_err=1, rsp_dat=0; ack at cycle 8 -> rsp_err=0.
REQ-036 Reset asserted asynchronously mid-BUS -> cyc/stb low before next clock edge; no rsp_valid; after release, a new read completes normally.
REQ-037 Spurious wbm_ack_i pulses in IDLE/RESP -> no state or output change.
